// File: rtl/multicycle_control_32_pkg.sv
// Purpose: shared state encoding, opcodes, ALUOp and mux codes for the multi-cycle MIPS control unit.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a. Optional feature macro: MULTICYCLE_ADDI_EN (adds the addi states and opcode).
package mips_ctrl_pkg;

    // Controller state codes; debug tools read these numbers off the state port.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    // Instruction opcodes (instruction bits [31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // ALUOp codes, shared with ALUControl_32.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    // PC source mux select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every datapath control the FSM produces, in one bundle.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // True for opcodes this build knows how to execute.
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_J);
`ifdef MULTICYCLE_ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_control_32_if.sv
// Purpose: bundles the opcode/memory handshake inputs and all datapath controls of the control unit.
// Latency: n/a (wires only).
// Backpressure: mem_ready from memory stalls the controller in its memory states.
interface multicycle_control_32_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ALUOp;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    // Controller side: reads opcode/handshake, drives the datapath.
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALUOp,
               pc_source, illegal_op, state
    );

    // Datapath side: supplies opcode/handshake, consumes the controls.
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ALUOp,
               pc_source, illegal_op, state
    );
endinterface

// File: rtl/ctrl_output_decode_32.sv
// Purpose: Moore output decoder from controller state to datapath controls (MULTICYCLE_ADDI_EN adds addi states).
// Latency: combinational, zero cycles.
// Backpressure: FETCH qualifies pc_write/ir_write with mem_ready so a stalled fetch never writes.
module ctrl_output_decode_32
    import mips_ctrl_pkg::*;
(
    input  logic       reset,
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic [3:0] state_out
);

    // Decode each state into its control pattern; reset blanks everything and reports FETCH.
    always_comb begin
        ctrl      = '0;
        state_out = state;
        if (reset) begin
            state_out = S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = ALUB_FOUR;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b  = ALUB_IMM_SH2;
                    ctrl.illegal_op = ~op_supported(opcode);
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = ALUB_IMM;
                end
                S_MEM_READ: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                S_EXECUTE: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
`ifdef MULTICYCLE_ADDI_EN
                S_ADDI_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = ALUB_IMM;
                end
                S_ADDI_WB: begin
                    ctrl.reg_write = 1'b1;
                end
`endif
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_32.sv
// Purpose: multi-cycle MIPS main control FSM (fetch/decode/execute/mem/wb); MULTICYCLE_ADDI_EN enables addi.
// Latency: Moore outputs straight from the state register; lw 5, R/sw/addi 4, beq/j 3, illegal 2 cycles.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold while mem_ready is low, one extra cycle per stall.
module multicycle_control_32
    import mips_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_32_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    logic       is_store_q;
    ctrl_t      ctrl;
    logic [3:0] state_dbg;

    // Next-state selection; opcode is only looked at in DECODE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WRITE: begin
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE:   state_d = S_R_WB;
`ifdef MULTICYCLE_ADDI_EN
            S_ADDI_EXEC: state_d = S_ADDI_WB;
`endif
            // Write-back, branch, jump and any unused code return to fetch.
            default:     state_d = S_FETCH;
        endcase
    end

    // State register plus the lw/sw choice captured in DECODE, since opcode is ignored afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            is_store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) is_store_q <= (bus.opcode == OP_SW);
        end
    end

    ctrl_output_decode_32 u_decode (
        .reset     (reset),
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .opcode    (bus.opcode),
        .ctrl      (ctrl),
        .state_out (state_dbg)
    );

    // Fan the control bundle out onto the interface.
    always_comb begin
        bus.pc_write      = ctrl.pc_write;
        bus.pc_write_cond = ctrl.pc_write_cond;
        bus.i_or_d        = ctrl.i_or_d;
        bus.mem_read      = ctrl.mem_read;
        bus.mem_write     = ctrl.mem_write;
        bus.ir_write      = ctrl.ir_write;
        bus.mem_to_reg    = ctrl.mem_to_reg;
        bus.reg_dst       = ctrl.reg_dst;
        bus.reg_write     = ctrl.reg_write;
        bus.alu_src_a     = ctrl.alu_src_a;
        bus.alu_src_b     = ctrl.alu_src_b;
        bus.ALUOp         = ctrl.alu_op;
        bus.pc_source     = ctrl.pc_source;
        bus.illegal_op    = ctrl.illegal_op;
        bus.state         = state_dbg;
    end

endmodule

// File: doc/multicycle_control_32.md
# multicycle_control_32

Multi-cycle main control unit for the 32-bit MIPS datapath. It is a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction. It drives every datapath enable and mux select, including the 2-bit `ALUOp` code consumed by `ALUControl_32`. It sits between the instruction register's opcode field and the datapath, and stalls on a memory-ready handshake.

## Interface
Parameters:
- none; opcodes and state codes come from the shared package.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  instruction bits [31:26], taken from the instruction register.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`  out  1 each  datapath enables/selects.
- `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath enables/selects.
- `alu_src_b`  out  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `ALUOp`  out  2  to `ALUControl_32`: 00 = add, 01 = subtract, 10 = use the funct field.
- `pc_source`  out  2  PC mux: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op`  out  1  one-cycle pulse for an unsupported opcode.
- `state`  out  4  current state code, for debug.

## Operation
- Opcodes:
  - R-type = 6'h00
  - lw = 6'h23
  - sw = 6'h2B
  - beq = 6'h04
  - j = 6'h02
  - addi = 6'h08
- States and transitions:
  - FETCH → DECODE (when `mem_ready` is 1).
  - DECODE → MEM_ADDR for lw/sw; EXECUTE for R-type; BRANCH for beq; JUMP for j; ADDI_EXEC for addi; FETCH for any other opcode.
  - MEM_ADDR → MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ → MEM_WB (when `mem_ready` is 1).
  - MEM_WRITE → FETCH (when `mem_ready` is 1).
  - EXECUTE → R_WB.
  - ADDI_EXEC → ADDI_WB.
  - MEM_WB, R_WB, ADDI_WB, BRANCH and JUMP → FETCH.
- Outputs per state. Any signal not listed is 0.
  - FETCH: `mem_read`=1, `alu_src_b`=01, `ir_write`=`mem_ready`, `pc_write`=`mem_ready`.
  - DECODE: `alu_src_b`=11.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10.
  - MEM_READ: `mem_read`=1, `i_or_d`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1.
  - MEM_WRITE: `mem_write`=1, `i_or_d`=1.
  - EXECUTE: `alu_src_a`=1, `ALUOp`=10.
  - R_WB: `reg_dst`=1, `reg_write`=1.
  - BRANCH: `alu_src_a`=1, `ALUOp`=01, `pc_write_cond`=1, `pc_source`=01.
  - JUMP: `pc_write`=1, `pc_source`=10.
  - ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10.
  - ADDI_WB: `reg_write`=1.
- `illegal_op` is 1 only in DECODE, and only when `opcode` is unsupported.
- Memory handshake:
  - FETCH, MEM_READ and MEM_WRITE hold their state and outputs while `mem_ready` is 0.
  - `pc_write` and `ir_write` assert only in the FETCH cycle where `mem_ready` is 1, so the PC is never incremented twice.
- `opcode` is sampled only in DECODE. Changes in other states are ignored.

## Timing
- Outputs are pure Moore, decoded from the state register with no added latency. The single exception is the FETCH `mem_ready` qualification.
- Reset:
  - While `reset` is 1, all outputs are forced to 0 and `state` reads as FETCH.
  - The state register loads FETCH on the next edge.
  - The first fetch happens in the first cycle after `reset` deasserts.
  - Reset mid-instruction, including during a memory stall, aborts the instruction; no further writes are issued.
- Cycle counts with `mem_ready` held at 1:
  - lw: 5
  - R-type: 4
  - sw: 4
  - addi: 4
  - beq: 3
  - j: 3
  - unsupported opcode: 2
- Each cycle that `mem_ready` is 0 in a memory state adds one cycle.

## Configuration
- `MULTICYCLE_ADDI_EN`
  - Defined: the ADDI_EXEC and ADDI_WB states exist, and addi executes in 4 cycles.
  - Undefined: those states are not compiled in. Opcode 6'h08 is unsupported: `illegal_op` pulses in DECODE and the FSM returns to FETCH.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state encoding, 4-bit codes FETCH=0 through ADDI_WB=11;
  - the opcode constants;
  - the `ALUOp` codes (00 add, 01 sub, 10 funct), shared with `ALUControl_32`.
- Sub-module `ctrl_output_decode_32`: combinational decoder from state (and `mem_ready`) to the outputs. The top level holds only the state register and the next-state logic.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1 → all outputs 0 during reset; `state`=0 and `mem_read`=1 in the first cycle after release.
- R-type (`opcode`=6'h00), `mem_ready`=1 → states FETCH, DECODE, EXECUTE (`ALUOp`=10), R_WB (`reg_dst`=1, `reg_write`=1), then FETCH; 4 cycles.
- lw (6'h23), with `mem_ready` low for 2 cycles in MEM_READ → 7 cycles total; `mem_to_reg`=1 and `reg_write`=1 for exactly one cycle.
- beq (6'h04) → BRANCH has `ALUOp`=01, `pc_write_cond`=1, `pc_source`=01; 3 cycles. j (6'h02) → JUMP has `pc_write`=1, `pc_source`=10.
- `mem_ready`=0 for 3 cycles in FETCH → `pc_write` and `ir_write` are 0 throughout the stall and assert exactly once, on the ready cycle.
- `opcode`=6'h08 → with `MULTICYCLE_ADDI_EN`: ADDI_EXEC (`alu_src_b`=10), ADDI_WB (`reg_write`=1). Without it: `illegal_op`=1 for one cycle in DECODE, then FETCH, with no `reg_write`.
